// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: lane geometry, the k -> (i,j) lane index mapping
// and the loader FSM state type.
package keccak_pkg;
  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;
  localparam int STRING_W  = 1600;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Stream word k carries lane a<i><j> with k = i + 5*j
  function automatic int lane_i(input int k);
    return k % 5;
  endfunction

  function automatic int lane_j(input int k);
    return k / 5;
  endfunction
endpackage

// File: rtl/stringtostate.sv
// Combinational split of a 1600-bit Keccak string into 25 lanes [i][j];
// word 0 (string MSBs) is lane a00.
module stringtostate
  import keccak_pkg::*;
(
  input  logic [STRING_W-1:0]           str,
  output logic [4:0][4:0][LANE_W-1:0]   lane
);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign lane[lane_i(gi)][lane_j(gi)] = str[STRING_W-1-LANE_W*gi -: LANE_W];
  end

endmodule

// File: rtl/stringtostate_loader.sv
// Serial-to-parallel loader: collects RATE_WORDS 64-bit words into a 1600-bit
// block and holds it on lanes a00..a44 until consumed. Optional macro
// STRINGTOSTATE_ABSORB_XOR_EN makes accepted words XOR into their lane.
module stringtostate_loader
  import keccak_pkg::*;
#(
  parameter int RATE_WORDS = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [LANE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] a00, a10, a20, a30, a40,
  output logic [LANE_W-1:0] a01, a11, a21, a31, a41,
  output logic [LANE_W-1:0] a02, a12, a22, a32, a42,
  output logic [LANE_W-1:0] a03, a13, a23, a33, a43,
  output logic [LANE_W-1:0] a04, a14, a24, a34, a44
);

  localparam logic [4:0] LAST = 5'(RATE_WORDS - 1);

  state_t                    state_reg, state_next;
  logic [4:0]                count_reg, count_next;
  logic [STRING_W-1:0]       block_reg;
  logic [4:0][4:0][LANE_W-1:0] lanes;
  logic                      accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FILL;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // in_ready depends only on state and clr, never on in_valid/out_ready
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    in_ready   = ~rst & ~clr & (state_reg == FILL);
    accept     = in_valid & in_ready;
    if (clr) begin
      state_next = FILL;
      count_next = '0;
    end else begin
      case (state_reg)
        FILL: begin
          if (accept) begin
            if (count_reg == LAST) begin
              state_next = FULL;
              count_next = '0;
            end else begin
              count_next = count_reg + 5'd1;
            end
          end
        end
        FULL: begin
          if (out_ready) state_next = FILL;
        end
        default: state_next = FILL;
      endcase
    end
  end

  assign out_valid = (state_reg == FULL);

  // Capacity words (k >= RATE_WORDS) are only ever zeroed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_reg <= '0;
    end else if (clr) begin
      block_reg <= '0;
    end else if (accept) begin
      for (int k = 0; k < RATE_WORDS; k++) begin
        if (count_reg == 5'(k)) begin
`ifdef STRINGTOSTATE_ABSORB_XOR_EN
          block_reg[STRING_W-1-LANE_W*k -: LANE_W] <=
            block_reg[STRING_W-1-LANE_W*k -: LANE_W] ^ in_data;
`else
          block_reg[STRING_W-1-LANE_W*k -: LANE_W] <= in_data;
`endif
        end
      end
    end
  end

  stringtostate u_split (
    .str  (block_reg),
    .lane (lanes)
  );

  assign a00 = lanes[0][0];
  assign a10 = lanes[1][0];
  assign a20 = lanes[2][0];
  assign a30 = lanes[3][0];
  assign a40 = lanes[4][0];
  assign a01 = lanes[0][1];
  assign a11 = lanes[1][1];
  assign a21 = lanes[2][1];
  assign a31 = lanes[3][1];
  assign a41 = lanes[4][1];
  assign a02 = lanes[0][2];
  assign a12 = lanes[1][2];
  assign a22 = lanes[2][2];
  assign a32 = lanes[3][2];
  assign a42 = lanes[4][2];
  assign a03 = lanes[0][3];
  assign a13 = lanes[1][3];
  assign a23 = lanes[2][3];
  assign a33 = lanes[3][3];
  assign a43 = lanes[4][3];
  assign a04 = lanes[0][4];
  assign a14 = lanes[1][4];
  assign a24 = lanes[2][4];
  assign a34 = lanes[3][4];
  assign a44 = lanes[4][4];

endmodule

// File: tb/tb_stringtostate_loader.sv
// Self-checking bench: two loaders (RATE_WORDS 25 and 17) share one stimulus
// stream; a block-level reference model feeds a scoreboard of expected blocks.
module tb_stringtostate_loader;

  typedef logic [24:0][63:0] blk_t;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [63:0] in_data;
  logic [1:0]  in_ready, out_valid;
  blk_t        l25, l17;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stringtostate_loader #(.RATE_WORDS(25)) dut25 (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
    .a00(l25[0]),  .a10(l25[1]),  .a20(l25[2]),  .a30(l25[3]),  .a40(l25[4]),
    .a01(l25[5]),  .a11(l25[6]),  .a21(l25[7]),  .a31(l25[8]),  .a41(l25[9]),
    .a02(l25[10]), .a12(l25[11]), .a22(l25[12]), .a32(l25[13]), .a42(l25[14]),
    .a03(l25[15]), .a13(l25[16]), .a23(l25[17]), .a33(l25[18]), .a43(l25[19]),
    .a04(l25[20]), .a14(l25[21]), .a24(l25[22]), .a34(l25[23]), .a44(l25[24])
  );

  stringtostate_loader #(.RATE_WORDS(17)) dut17 (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
    .a00(l17[0]),  .a10(l17[1]),  .a20(l17[2]),  .a30(l17[3]),  .a40(l17[4]),
    .a01(l17[5]),  .a11(l17[6]),  .a21(l17[7]),  .a31(l17[8]),  .a41(l17[9]),
    .a02(l17[10]), .a12(l17[11]), .a22(l17[12]), .a32(l17[13]), .a42(l17[14]),
    .a03(l17[15]), .a13(l17[16]), .a23(l17[17]), .a33(l17[18]), .a43(l17[19]),
    .a04(l17[20]), .a14(l17[21]), .a24(l17[22]), .a34(l17[23]), .a44(l17[24])
  );

  // Reference model: per instance, an array of words, a fill index and a "held" flag
  blk_t m_lane [2];
  int   m_cnt  [2];
  bit   m_full [2];
  int   rate   [2] = '{25, 17};
  blk_t exp_q0[$];
  blk_t exp_q1[$];
  bit   prev_ov[2] = '{1'b0, 1'b0};

  task automatic model_step();
    for (int n = 0; n < 2; n++) begin
      if (rst || clr) begin
        m_lane[n] = '0;
        m_cnt[n]  = 0;
        m_full[n] = 1'b0;
      end else if (m_full[n]) begin
        if (out_ready) m_full[n] = 1'b0;
      end else if (in_valid) begin
`ifdef STRINGTOSTATE_ABSORB_XOR_EN
        m_lane[n][m_cnt[n]] = m_lane[n][m_cnt[n]] ^ in_data;
`else
        m_lane[n][m_cnt[n]] = in_data;
`endif
        m_cnt[n] = m_cnt[n] + 1;
        if (m_cnt[n] == rate[n]) begin
          m_cnt[n]  = 0;
          m_full[n] = 1'b1;
          if (n == 0) exp_q0.push_back(m_lane[n]);
          else        exp_q1.push_back(m_lane[n]);
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic chkblk(input string nm, input blk_t got, input blk_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      for (int k = 0; k < 25; k++) begin
        if (got[k] !== exp[k]) begin
          $display("FAIL %s word k=%0d got=%h want=%h", nm, k, got[k], exp[k]);
          break;
        end
      end
    end
  endtask

  task automatic monitor_step();
    blk_t exp_blk;
    for (int n = 0; n < 2; n++) begin
      blk_t got = (n == 0) ? l25 : l17;
      string tag = (n == 0) ? "r25" : "r17";
      chk({tag, "_in_ready"}, {63'b0, in_ready[n]},
          {63'b0, ~rst & ~clr & ~m_full[n]});
      chk({tag, "_out_valid"}, {63'b0, out_valid[n]}, {63'b0, m_full[n]});
      chkblk({tag, "_lanes"}, got, m_lane[n]);
      if (out_valid[n] && !prev_ov[n]) begin
        total++;
        if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
          bad++;
          $display("FAIL %s_scoreboard got=block want=none", tag);
        end else begin
          exp_blk = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          total--;
          chkblk({tag, "_block"}, got, exp_blk);
          $display("block %s a00=%h a44=%h", tag, got[0], got[24]);
        end
      end
      prev_ov[n] = out_valid[n];
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
  endtask

  task automatic handshake();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    in_valid = 1'b0;
    clr      = 1'b1;
    step();
    clr      = 1'b0;
  endtask

  logic [63:0] xor_exp;
  int          accepted;

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset in the middle of a partial block
    for (int k = 0; k < 5; k++) push_word(64'hDEAD_0000 + 64'(k));
    in_valid = 1'b1;
    rst = 1'b1;
    step();
    chk("in_ready_during_rst", {63'b0, in_ready[0]}, 64'd0);
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", {63'b0, in_ready[0]}, 64'd1);
    chk("out_valid_after_rst", {63'b0, out_valid[0]}, 64'd0);
    chk("a00_after_rst", l25[0], 64'd0);

    // Full block of words k+1
    for (int k = 0; k < 25; k++) push_word(64'(k + 1));
    chk("full_out_valid", {63'b0, out_valid[0]}, 64'd1);
    chk("full_a00", l25[0], 64'd1);
    chk("full_a10", l25[1], 64'd2);
    chk("full_a40", l25[4], 64'd5);
    chk("full_a01", l25[5], 64'd6);
    chk("full_a44", l25[24], 64'd25);

    // Backpressure: words offered while the block is held
    for (int c = 0; c < 10; c++) push_word(64'hBAD0 + 64'(c));
    chk("bp_in_ready", {63'b0, in_ready[0]}, 64'd0);
    chk("bp_a44_hold", l25[24], 64'd25);
    handshake();
    chk("hs_out_valid", {63'b0, out_valid[0]}, 64'd0);
    chk("hs_in_ready", {63'b0, in_ready[0]}, 64'd1);
    chk("hs_a00_kept", l25[0], 64'd1);

    // Rate 17 block
    clr_pulse();
    for (int k = 0; k < 17; k++) push_word(64'hA5A5_A5A5_A5A5_A5A5);
    in_valid = 1'b0;
    chk("r17_out_valid", {63'b0, out_valid[1]}, 64'd1);
    chk("r17_a12", l17[11], 64'hA5A5_A5A5_A5A5_A5A5);
    chk("r17_a23", l17[17], 64'd0);
    chk("r17_a44", l17[24], 64'd0);
    chk("r25_not_full", {63'b0, out_valid[0]}, 64'd0);
    handshake();

    // Gapped partial block, then clr colliding with a valid word
    clr_pulse();
    accepted = 0;
    for (int c = 0; c < 200 && accepted < 10; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom};
      if (in_valid) accepted++;
      step();
    end
    in_valid = 1'b1;
    in_data  = 64'hFFFF_0000_FFFF_0000;
    clr      = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clr_in_ready", {63'b0, in_ready[0]}, 64'd1);
    chk("clr_a00", l25[0], 64'd0);
    chk("clr_word10", l25[10], 64'd0);
    for (int k = 0; k < 25; k++) push_word({$urandom, $urandom});
    in_valid = 1'b0;
    chk("fresh_out_valid", {63'b0, out_valid[0]}, 64'd1);
    handshake();

    // Absorb behaviour: second block either overwrites or XORs into the first
    clr_pulse();
    for (int k = 0; k < 25; k++) push_word('1);
    handshake();
    for (int k = 0; k < 25; k++) push_word(64'h0F0F_0F0F_0F0F_0F0F);
    in_valid = 1'b0;
`ifdef STRINGTOSTATE_ABSORB_XOR_EN
    xor_exp = 64'hF0F0_F0F0_F0F0_F0F0;
`else
    xor_exp = 64'h0F0F_0F0F_0F0F_0F0F;
`endif
    chk("absorb_a00", l25[0], xor_exp);
    handshake();
    clr_pulse();
    chk("absorb_clr_a00", l25[0], 64'd0);
    chk("absorb_clr_a44", l25[24], 64'd0);

    // Random traffic with occasional clr
    for (int c = 0; c < 600; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) == 0);
      clr       = ($urandom_range(0, 49) == 0);
      in_data   = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
